mem_arb: RTL

Round-robin arbiter that shares the single memory port used by the SUBLEQ core between `NREQ` requesters, for example several cores, or a core plus a host/debug loader. Each requester drives a request/grant handshake. Per cycle, the arbiter forwards exactly one granted access to the memory read or write port. For granted reads, it returns the data one cycle later with a per-requester `rvalid` strobe. An optional lock lets one requester keep the port across a read-modify-write sequence.

---
 rtl/mem_arb.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arb : round-robin arbiter sharing one memory port among NREQ         |
// |           requesters; optional grant lock enabled by MEM_ARB_LOCK_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_arb #(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  input  logic [NREQ-1:0]      lock,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [DW-1:0]        rdata,
  output logic                 mem_rd_en,
  output logic [AW-1:0]        mem_rd_addr,
  input  logic [DW-1:0]        mem_rd_data,
  output logic                 mem_wr_en,
  output logic [AW-1:0]        mem_wr_addr,
  output logic [DW-1:0]        mem_wr_data
);

  localparam int            PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] C_LAST = PW'(NREQ - 1);
  localparam logic [PW-1:0] C_ONE  = PW'(1);

  logic [PW-1:0] ptr_q, ptr_d;
  logic          quiet_q, quiet_d;
  logic          rd_tag_vld_q, rd_tag_vld_d;
  logic [PW-1:0] rd_tag_q, rd_tag_d;

  logic          quiet;
  logic [NREQ-1:0] req_eff;
  logic          gnt_any;
  logic [PW-1:0] gnt_idx;

  // Outputs stay silent during reset and for one cycle after it.
  assign quiet = rst | quiet_q;

`ifdef MEM_ARB_LOCK_EN
  logic          own_vld_q, own_vld_d;
  logic [PW-1:0] own_q, own_d;

  always_comb begin
    req_eff = req;
    if (own_vld_q) begin
      req_eff = req & (NREQ'(1) << own_q);
    end
  end

  always_comb begin
    own_vld_d = own_vld_q;
    own_d     = own_q;
    if (own_vld_q && !req[own_q]) begin
      own_vld_d = 1'b0;
    end else if (gnt_any) begin
      own_vld_d = lock[gnt_idx];
      own_d     = gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      own_vld_q <= 1'b0;
      own_q     <= '0;
    end else begin
      own_vld_q <= own_vld_d;
      own_q     <= own_d;
    end
  end
`else
  logic [NREQ-1:0] unused_lock;
  assign unused_lock = lock;
  assign req_eff     = req;
`endif

  // First requester found walking upward from ptr, with wrap-around.
  always_comb begin : p_grant
    int            s;
    logic [PW-1:0] idx;
    s       = 0;
    idx     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = int'(ptr_q) + k;
      if (s >= NREQ) begin
        s = s - NREQ;
      end
      idx = PW'(s);
      if (!quiet && !gnt_any && req_eff[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign gnt = gnt_any ? (NREQ'(1) << gnt_idx) : '0;

  always_comb begin
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        if (we[i]) begin
          mem_wr_en   = 1'b1;
          mem_wr_addr = addr[i*AW +: AW];
          mem_wr_data = wdata[i*DW +: DW];
        end else begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = addr[i*AW +: AW];
        end
      end
    end
  end

  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (!quiet && rd_tag_vld_q) begin
      rvalid = NREQ'(1) << rd_tag_q;
      rdata  = mem_rd_data;
    end
  end

  always_comb begin
    quiet_d      = rst;
    ptr_d        = ptr_q;
    rd_tag_vld_d = gnt_any & ~we[gnt_idx];
    rd_tag_d     = gnt_idx;
    if (gnt_any) begin
      ptr_d = (gnt_idx == C_LAST) ? '0 : gnt_idx + C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    quiet_q <= quiet_d;
    if (rst) begin
      ptr_q        <= '0;
      rd_tag_vld_q <= 1'b0;
      rd_tag_q     <= '0;
    end else begin
      ptr_q        <= ptr_d;
      rd_tag_vld_q <= rd_tag_vld_d;
      rd_tag_q     <= rd_tag_d;
    end
  end

endmodule
`default_nettype wire
